// File: rtl/wb_fir_stream_bridge.sv
// Wishbone slave to AXI-Stream bridge for the FIR core.
// X/X_LAST writes feed an input FIFO that streams out on ss_*, FIR results
// arriving on sm_* land in an output FIFO drained by Y reads. Accesses that
// cannot complete insert wait states, bounded by a stall timeout.
module wb_fir_stream_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ss_tvalid,
  output logic        ss_tlast,
  output logic [31:0] ss_tdata,
  input  logic        ss_tready,
  input  logic        sm_tvalid,
  input  logic        sm_tlast,
  input  logic [31:0] sm_tdata,
  output logic        sm_tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [7:0] OFF_X      = 8'h80;
  localparam logic [7:0] OFF_Y      = 8'h84;
  localparam logic [7:0] OFF_STATUS = 8'h88;
  localparam logic [7:0] OFF_X_LAST = 8'h8C;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // FIFO storage and bookkeeping; bit 32 of each entry carries tlast
  logic [32:0]   in_mem_r  [DEPTH];
  logic [AW-1:0] in_wr_r;
  logic [AW-1:0] in_rd_r;
  logic [CW-1:0] in_count_r;
  logic [32:0]   out_mem_r [DEPTH];
  logic [AW-1:0] out_wr_r;
  logic [AW-1:0] out_rd_r;
  logic [CW-1:0] out_count_r;

  // Bus side state
  state_t        state_r;
  logic          ack_r;
  logic [31:0]   dat_r;
  logic [TW-1:0] stall_cnt_r;
  logic          pend_write_r;
  logic [32:0]   pend_word_r;
  logic          last_seen_r;
  logic          timeout_err_r;

  // Combinational helpers
  logic          in_full_s;
  logic          in_empty_s;
  logic          out_full_s;
  logic          out_empty_s;
  logic [32:0]   in_head_s;
  logic [32:0]   out_head_s;
  logic          req_s;
  logic [7:0]    off_s;
  logic          is_x_wr_s;
  logic          is_x_last_s;
  logic          is_y_rd_s;
  logic          is_status_rd_s;
  logic          idle_go_s;
  logic          stall_live_s;
  logic          wb_push_s;
  logic          wb_pop_s;
  logic [32:0]   wb_push_word_s;
  logic          ss_pop_s;
  logic          sm_push_s;
  logic [31:0]   status_s;
  logic          unused_sel_s;

  assign unused_sel_s = &{1'b0, wbs_sel_i};

  assign in_full_s   = (in_count_r == FULL_CNT);
  assign in_empty_s  = (in_count_r == {CW{1'b0}});
  assign out_full_s  = (out_count_r == FULL_CNT);
  assign out_empty_s = (out_count_r == {CW{1'b0}});
  assign in_head_s   = in_mem_r[in_rd_r];
  assign out_head_s  = out_mem_r[out_rd_r];

  // Address decode; a request is never re-decoded while its ack is showing
  assign req_s          = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign off_s          = wbs_adr_i[7:0];
  assign is_x_last_s    = (off_s == OFF_X_LAST);
  assign is_x_wr_s      = wbs_we_i && ((off_s == OFF_X) || is_x_last_s);
  assign is_y_rd_s      = !wbs_we_i && (off_s == OFF_Y);
  assign is_status_rd_s = !wbs_we_i && (off_s == OFF_STATUS);
  assign idle_go_s      = (state_r == ST_IDLE) && req_s && !ack_r;
  assign stall_live_s   = (state_r == ST_STALL) && wbs_cyc_i && wbs_stb_i;

  // FIFO moves caused by the bus; they land on the edge that raises ack
  assign wb_push_s = (idle_go_s && is_x_wr_s && !in_full_s)
                   || (stall_live_s && pend_write_r && !in_full_s);
  assign wb_pop_s  = (idle_go_s && is_y_rd_s && !out_empty_s)
                   || (stall_live_s && !pend_write_r && !out_empty_s);
  assign wb_push_word_s = (state_r == ST_STALL) ? pend_word_r : {is_x_last_s, wbs_dat_i};

  // Stream handshakes
  assign ss_pop_s  = !in_empty_s && ss_tready;
  assign sm_push_s = sm_tvalid && !out_full_s;

  assign ss_tvalid = !in_empty_s;
  assign ss_tdata  = in_empty_s ? 32'd0 : in_head_s[31:0];
  assign ss_tlast  = in_empty_s ? 1'b0 : in_head_s[32];
  assign sm_tready = !out_full_s;

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;

  assign status_s = {16'h0000, 4'(out_count_r), 4'(in_count_r), 2'b00,
                     timeout_err_r, last_seen_r, out_empty_s, out_full_s,
                     in_empty_s, in_full_s};

  // Input FIFO storage write (bus side)
  always_ff @(posedge wb_clk_i) begin
    if (wb_push_s) in_mem_r[in_wr_r] <= wb_push_word_s;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_wr_r    <= {AW{1'b0}};
      in_rd_r    <= {AW{1'b0}};
      in_count_r <= {CW{1'b0}};
    end else begin
      if (wb_push_s) in_wr_r <= in_wr_r + PTR_ONE;
      if (ss_pop_s)  in_rd_r <= in_rd_r + PTR_ONE;
      case ({wb_push_s, ss_pop_s})
        2'b10:   in_count_r <= in_count_r + CNT_ONE;
        2'b01:   in_count_r <= in_count_r - CNT_ONE;
        default: in_count_r <= in_count_r;
      endcase
    end
  end

  // Output FIFO storage write (stream side)
  always_ff @(posedge wb_clk_i) begin
    if (sm_push_s) out_mem_r[out_wr_r] <= {sm_tlast, sm_tdata};
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_wr_r    <= {AW{1'b0}};
      out_rd_r    <= {AW{1'b0}};
      out_count_r <= {CW{1'b0}};
    end else begin
      if (sm_push_s) out_wr_r <= out_wr_r + PTR_ONE;
      if (wb_pop_s)  out_rd_r <= out_rd_r + PTR_ONE;
      case ({sm_push_s, wb_pop_s})
        2'b10:   out_count_r <= out_count_r + CNT_ONE;
        2'b01:   out_count_r <= out_count_r - CNT_ONE;
        default: out_count_r <= out_count_r;
      endcase
    end
  end

  // Bus FSM: decode, stall/timeout tracking, registered ack/data, sticky bits
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r       <= ST_IDLE;
      ack_r         <= 1'b0;
      dat_r         <= 32'd0;
      stall_cnt_r   <= {TW{1'b0}};
      pend_write_r  <= 1'b0;
      pend_word_r   <= 33'd0;
      last_seen_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
      case (state_r)
        ST_IDLE: begin
          if (idle_go_s) begin
            if (is_x_wr_s) begin
              if (in_full_s) begin
                state_r      <= ST_STALL;
                pend_write_r <= 1'b1;
                pend_word_r  <= {is_x_last_s, wbs_dat_i};
                stall_cnt_r  <= {TW{1'b0}};
              end else begin
                ack_r <= 1'b1;
              end
            end else if (is_y_rd_s) begin
              if (out_empty_s) begin
                state_r      <= ST_STALL;
                pend_write_r <= 1'b0;
                pend_word_r  <= 33'd0;
                stall_cnt_r  <= {TW{1'b0}};
              end else begin
                ack_r <= 1'b1;
                dat_r <= out_head_s[31:0];
              end
            end else if (is_status_rd_s) begin
              // Reading STATUS clears the sticky bits after reporting them
              ack_r         <= 1'b1;
              dat_r         <= status_s;
              last_seen_r   <= 1'b0;
              timeout_err_r <= 1'b0;
            end else begin
              ack_r <= 1'b1;
            end
          end
        end
        ST_STALL: begin
          if (!(wbs_cyc_i && wbs_stb_i)) begin
            // Master gave up: drop the access silently
            state_r     <= ST_IDLE;
            stall_cnt_r <= {TW{1'b0}};
          end else if (wb_push_s) begin
            state_r     <= ST_IDLE;
            stall_cnt_r <= {TW{1'b0}};
            ack_r       <= 1'b1;
          end else if (wb_pop_s) begin
            state_r     <= ST_IDLE;
            stall_cnt_r <= {TW{1'b0}};
            ack_r       <= 1'b1;
            dat_r       <= out_head_s[31:0];
          end else if (stall_cnt_r == TO_LAST) begin
            // Forced completion: no FIFO change, error flagged
            state_r       <= ST_IDLE;
            stall_cnt_r   <= {TW{1'b0}};
            ack_r         <= 1'b1;
            dat_r         <= pend_write_r ? 32'd0 : 32'hFFFF_FFFF;
            timeout_err_r <= 1'b1;
          end else begin
            stall_cnt_r <= stall_cnt_r + TO_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          stall_cnt_r <= {TW{1'b0}};
        end
      endcase
      // A tagged entry leaving through Y sets last_seen; placed last so it wins
      if (wb_pop_s && out_head_s[32]) last_seen_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_fir_stream_bridge.sv
// Self-checking bench for wb_fir_stream_bridge (DEPTH=4, TIMEOUT=16).
// Stream words and Y read data are predicted into queues as stimulus is
// driven and compared when the DUT produces them.
module tb_wb_fir_stream_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat_o;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_ss [$];
  logic [32:0] loop_q [$];
  logic [31:0] exp_y  [$];
  bit          loop_en = 1'b0;

  always #5 clk = ~clk;

  wb_fir_stream_bridge #(.BASE_ADR(BASE), .DEPTH(4), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst && ss_tvalid && ss_tready) begin
      if (exp_ss.size() == 0) begin
        check_eq("ss_unexpected", {ss_tlast, ss_tdata}, 64'd0);
      end else begin
        check_eq("ss_word", {ss_tlast, ss_tdata}, exp_ss.pop_front());
      end
      if (loop_en) loop_q.push_back({ss_tlast, ss_tdata});
    end
  end

  // One Wishbone access; waited = edges between request sample and ack edge
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int budget, output bit acked, output int waited,
                         output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    acked = 1'b0; waited = 0; rd = 32'd0;
    @(posedge clk);
    @(negedge clk);
    while (!ack && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (ack) begin
      acked = 1'b1;
      rd = rdat_o;
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr_chk(input logic [7:0] off, input logic [31:0] d, input int exp_wait, input string tag);
    bit a; int wt; logic [31:0] r;
    wb_xfer(1'b1, BASE | {24'd0, off}, d, 40, a, wt, r);
    check_eq({tag, "_ack"}, {63'd0, a}, 64'd1);
    check_eq({tag, "_wait"}, 64'(wt), 64'(exp_wait));
  endtask

  task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp_d, input int exp_wait, input string tag);
    bit a; int wt; logic [31:0] r;
    wb_xfer(1'b0, BASE | {24'd0, off}, 32'd0, 40, a, wt, r);
    check_eq({tag, "_ack"}, {63'd0, a}, 64'd1);
    check_eq({tag, "_wait"}, 64'(wt), 64'(exp_wait));
    check_eq({tag, "_dat"}, {32'd0, r}, {32'd0, exp_d});
  endtask

  task automatic rd_y(input string tag);
    logic [31:0] e;
    if (exp_y.size() == 0) begin
      check_eq({tag, "_no_expect"}, 64'd1, 64'd0);
    end else begin
      e = exp_y.pop_front();
      rd_chk(8'h84, e, 0, tag);
    end
  endtask

  task automatic sm_send(input logic [31:0] d, input logic l);
    sm_tvalid = 1'b1; sm_tdata = d; sm_tlast = l;
    exp_y.push_back(d);
    @(posedge clk);
    #1;
    sm_tvalid = 1'b0; sm_tdata = 32'd0; sm_tlast = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_ss.size() != 0 && w < 30) begin
      @(posedge clk);
      w++;
    end
    #1;
    check_eq(tag, 64'(exp_ss.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a; int wt; logic [31:0] r; int seen; int w; logic [32:0] lw;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = 32'd0; wdat = 32'd0; ss_tready = 1'b0;
    sm_tvalid = 1'b0; sm_tlast = 1'b0; sm_tdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_ss_tvalid", {63'd0, ss_tvalid}, 64'd0);
    check_eq("rst_ss_tdata", {32'd0, ss_tdata}, 64'd0);
    check_eq("rst_sm_tready", {63'd0, sm_tready}, 64'd1);
    check_eq("rst_ack", {63'd0, ack}, 64'd0);
    rd_chk(8'h88, 32'h0000_000A, 0, "status_reset");

    // Fill input FIFO with the stream stalled, then a stalled fifth write
    for (int i = 1; i <= 4; i++) begin
      exp_ss.push_back({1'b0, 32'(i)});
      wr_chk(8'h80, 32'(i), 0, "x_fill");
    end
    rd_chk(8'h88, 32'h0000_0409, 0, "status_full");
    exp_ss.push_back({1'b0, 32'd5});
    fork
      wb_xfer(1'b1, BASE | 32'h80, 32'd5, 40, a, wt, r);
      begin
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 ss_tready = 1'b1;
      end
    join
    check_eq("x_stall_ack", {63'd0, a}, 64'd1);
    check_eq("x_stall_wait", 64'(wt), 64'd12);
    drain("ss_drain1");

    // X_LAST through an identity model FIR and back via Y
    loop_en = 1'b1;
    exp_ss.push_back({1'b1, 32'hDEAD_BEEF});
    wr_chk(8'h8C, 32'hDEAD_BEEF, 0, "xlast_wr");
    w = 0;
    while (loop_q.size() == 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    check_eq("loop_seen", 64'(loop_q.size()), 64'd1);
    loop_en = 1'b0;
    if (loop_q.size() != 0) begin
      lw = loop_q.pop_front();
      sm_send(lw[31:0], lw[32]);
    end
    rd_y("y_loop");
    rd_chk(8'h88, 32'h0000_001A, 0, "status_last");
    rd_chk(8'h88, 32'h0000_000A, 0, "status_last_clr");

    // Y read timeout on an empty output FIFO
    rd_chk(8'h84, 32'hFFFF_FFFF, TO, "y_timeout");
    rd_chk(8'h88, 32'h0000_002A, 0, "status_to");
    rd_chk(8'h88, 32'h0000_000A, 0, "status_to_clr");

    // Master abort of a stalled Y read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h84;
    seen = 0;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      if (ack) seen++;
    end
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack) seen++;
    end
    @(posedge clk);
    #1;
    check_eq("abort_no_ack", 64'(seen), 64'd0);
    rd_chk(8'h88, 32'h0000_000A, 0, "status_abort");
    // Counter must restart from zero after the abort
    rd_chk(8'h84, 32'hFFFF_FFFF, TO, "y_timeout2");
    rd_chk(8'h88, 32'h0000_002A, 0, "status_to2");
    sm_send(32'h0000_0055, 1'b0);
    rd_y("y_55");
    rd_chk(8'h88, 32'h0000_000A, 0, "status_after55");

    // Other in-page offsets and an off-page address
    wr_chk(8'h00, 32'h1234_5678, 0, "misc_wr");
    rd_chk(8'h04, 32'h0000_0000, 0, "misc_rd");
    rd_chk(8'h80, 32'h0000_0000, 0, "x_read");
    wb_xfer(1'b0, BASE + 32'h100, 32'd0, 8, a, wt, r);
    check_eq("offpage_no_ack", {63'd0, a}, 64'd0);
    rd_chk(8'h88, 32'h0000_000A, 0, "status_misc");

    // Write into a full FIFO on the same edge as a stream pop
    ss_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_ss.push_back({1'b0, 32'hA0 + 32'(i)});
      wr_chk(8'h80, 32'hA0 + 32'(i), 0, "x_fill2");
    end
    exp_ss.push_back({1'b0, 32'hA4});
    ss_tready = 1'b1;
    fork
      wb_xfer(1'b1, BASE | 32'h80, 32'hA4, 40, a, wt, r);
      begin
        @(posedge clk);
        #1 ss_tready = 1'b0;
      end
    join
    check_eq("simul_ack", {63'd0, a}, 64'd1);
    check_eq("simul_wait", 64'(wt), 64'd1);
    rd_chk(8'h88, 32'h0000_0409, 0, "status_simul");
    ss_tready = 1'b1;
    drain("ss_drain2");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
